pmem_burst_ctrl: RTL and testbench
==================================

PMEM_BURST_CTRL -- requirements
Module: pmem_burst_ctrl

Interface
REQ-001 SHALL take parameter ADDR_W, default 32, meaning physical address width.
REQ-002 SHALL take parameter BEAT_W, default 64, meaning burst beat width.
REQ-003 SHALL take parameter BEATS, default 4, meaning beats per cache line (line = 256 bits).
REQ-004 SHALL take parameter LATENCY, default 4, meaning cycles from accept to first beat; legal range 1..15.
REQ-005 SHALL take parameter IDX_W, default 8, meaning log2 of backing-store depth in lines.
REQ-006 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port mem_address  input  ADDR_W  line address of the request.
REQ-009 SHALL have port mem_read  input  1  burst read request, held until last beat.
REQ-010 SHALL have port mem_write  input  1  burst write request, held until last beat.
REQ-011 SHALL have port mem_wdata  input  BEAT_W  current write beat.
REQ-012 SHALL have port mem_resp  output  1  beat strobe, one per transferred beat.
REQ-013 SHALL have port mem_rdata  output  BEAT_W  read beat, valid while mem_resp=1 on reads.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, WAIT, BURST, DONE.
REQ-016 SHALL, in IDLE with mem_read or mem_write high, latch address, op and line index = mem_address[5+IDX_W-1:5], load latency counter with LATENCY-1, and go to WAIT.
REQ-017 SHALL ignore mem_address[4:0]; upper bits above the index SHALL be ignored (index wraps modulo 2^IDX_W).
REQ-018 SHALL treat mem_read and mem_write both high in IDLE as a read.
REQ-019 SHALL, in WAIT, decrement the counter each cycle and enter BURST when it reaches 0, so first mem_resp occurs LATENCY+1 cycles after the accepting edge.
REQ-020 SHALL, in BURST, assert mem_resp for exactly BEATS consecutive cycles with a 2-bit beat counter starting at 0.
REQ-021 SHALL, on reads, drive mem_rdata with line[index] bits [64k+63:64k] during beat k, registered, and 0 when mem_resp=0.
REQ-022 SHALL, on writes, capture mem_wdata into beat k of line[index] on the edge ending beat k; requester changes mem_wdata only after seeing mem_resp.
REQ-023 SHALL go to DONE after beat BEATS-1, hold mem_resp=0 there for one cycle ignoring requests, then return to IDLE.
REQ-024 SHALL abort to IDLE on the next edge if the latched op's request drops during WAIT or BURST; beats already written remain written.
REQ-025 SHALL ignore mem_address and the opposite op's request changes after acceptance.

Reset
REQ-026 SHALL, on rst high, enter IDLE and force mem_resp=0, mem_rdata=0, busy=0, counters=0 at the next edge, including mid-burst.
REQ-027 SHALL NOT clear backing-store contents on reset.

Structure
REQ-028 SHALL place the state enum, LINE_W=256, OFFSET_W=5 and the default parameter values in shared package cache_pkg.
REQ-029 SHALL isolate the backing store in sub-module line_ram (one write port at beat granularity, one registered read port).

Verification
REQ-030 Reset then read idx 3 (addr 0x60) after preloading 0x0..3 pattern -> mem_resp high cycles 5..8 after request, rdata 0x...0,1,2,3 in order.
REQ-031 Write addr 0x20 beats A0..A3, then read 0x20 -> rdata A0,A1,A2,A3; line 0 untouched.
REQ-032 Read and write both high at addr 0x40 -> read performed, line 2 unchanged.
REQ-033 Assert rst during beat 1 of a write -> mem_resp 0 next cycle, busy 0, beat 0 stored, beats 1..3 old values.
REQ-034 Drop mem_read in WAIT -> no mem_resp, IDLE next cycle; back-to-back read held through DONE -> second burst starts only after DONE.
REQ-035 Address 0x2020 with IDX_W=8 -> accesses line 1 (wrap), verified by readback via 0x20.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and default parameters for the physical-memory burst controller.
// Line geometry is fixed at 256 bits with a 5-bit byte offset.
package cache_pkg;

   localparam int LINE_W      = 256;
   localparam int OFFSET_W    = 5;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_BEAT_W  = 64;
   localparam int DEF_BEATS   = 4;
   localparam int DEF_LATENCY = 4;
   localparam int DEF_IDX_W   = 8;

   // Latency counter is sized for the full legal LATENCY range 1..15.
   localparam int LAT_CW      = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/line_ram.sv
// Backing store: one bank per beat so a write touches a single beat of a line;
// read port is registered (data appears the cycle after ridx/rbeat).
module line_ram
   import cache_pkg::*;
#(
   parameter int IDX_W  = DEF_IDX_W,
   parameter int BEAT_W = DEF_BEAT_W,
   parameter int BEATS  = DEF_BEATS,
   localparam int BEAT_CW = clog2_min1(BEATS)
) (
   input  logic               clk,
   input  logic               we,
   input  logic [IDX_W-1:0]   widx,
   input  logic [BEAT_CW-1:0] wbeat,
   input  logic [BEAT_W-1:0]  wdata,
   input  logic [IDX_W-1:0]   ridx,
   input  logic [BEAT_CW-1:0] rbeat,
   output logic [BEAT_W-1:0]  rdata
);

   localparam int DEPTH = 1 << IDX_W;

   logic [BEATS-1:0][BEAT_W-1:0] bank_q;
   logic [BEAT_CW-1:0]           rsel_q;

   for (genvar b = 0; b < BEATS; b++) begin : g_bank
      logic [BEAT_W-1:0] mem [DEPTH];
      logic [BEAT_W-1:0] q;

      // Contents are deliberately never reset.
      always_ff @(posedge clk) begin
         if (we && (wbeat == BEAT_CW'(b)))
            mem[widx] <= wdata;
         q <= mem[ridx];
      end

      assign bank_q[b] = q;
   end

   always_ff @(posedge clk)
      rsel_q <= rbeat;

   assign rdata = bank_q[rsel_q];

endmodule

// File: rtl/pmem_burst_ctrl.sv
// Burst controller: accepts a line read/write, waits LATENCY cycles, then
// streams BEATS beats against the line_ram backing store.
module pmem_burst_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int BEAT_W  = DEF_BEAT_W,
   parameter int BEATS   = DEF_BEATS,
   parameter int LATENCY = DEF_LATENCY,
   parameter int IDX_W   = DEF_IDX_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] mem_address,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [BEAT_W-1:0] mem_wdata,
   output logic              mem_resp,
   output logic [BEAT_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int BEAT_CW = clog2_min1(BEATS);

   state_t             state;
   op_t                op;
   logic [IDX_W-1:0]   idx;
   logic [LAT_CW-1:0]  lat_cnt;
   logic [BEAT_CW-1:0] beat;

   logic               req_held;
   logic               last_beat;
   logic               ram_we;
   logic [BEAT_CW-1:0] ram_rbeat;
   logic [BEAT_W-1:0]  ram_rdata;
   logic               unused_addr;

   // Only the index field selects a line; offset and upper bits are dropped.
   assign unused_addr = ^mem_address;

   // Only the accepted op's request keeps the burst alive.
   assign req_held  = (op == OP_WR) ? mem_write : mem_read;
   assign last_beat = (beat == BEAT_CW'(BEATS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         op       <= OP_RD;
         idx      <= '0;
         lat_cnt  <= '0;
         beat     <= '0;
         mem_resp <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_read || mem_write) begin
                  state   <= WAIT;
                  op      <= mem_read ? OP_RD : OP_WR;
                  idx     <= mem_address[OFFSET_W+IDX_W-1:OFFSET_W];
                  lat_cnt <= LAT_CW'(LATENCY - 1);
                  beat    <= '0;
                  busy    <= 1'b1;
               end
            end
            WAIT: begin
               if (!req_held) begin
                  state   <= IDLE;
                  lat_cnt <= '0;
                  busy    <= 1'b0;
               end else if (lat_cnt == '0) begin
                  state    <= BURST;
                  beat     <= '0;
                  mem_resp <= 1'b1;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            BURST: begin
               if (!req_held) begin
                  state    <= IDLE;
                  beat     <= '0;
                  mem_resp <= 1'b0;
                  busy     <= 1'b0;
               end else if (last_beat) begin
                  state    <= DONE;
                  beat     <= '0;
                  mem_resp <= 1'b0;
               end else begin
                  beat <= beat + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               mem_resp <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

   // A beat is written on the edge that ends it, unless reset or abort lands there.
   assign ram_we = !rst && (state == BURST) && (op == OP_WR) && mem_write;

   // Read port runs one beat ahead so registered data lines up with mem_resp;
   // the last WAIT cycle fetches beat 0.
   assign ram_rbeat = (state == BURST) ? beat + 1'b1 : '0;

   line_ram #(
      .IDX_W  (IDX_W),
      .BEAT_W (BEAT_W),
      .BEATS  (BEATS)
   ) u_line_ram (
      .clk   (clk),
      .we    (ram_we),
      .widx  (idx),
      .wbeat (beat),
      .wdata (mem_wdata),
      .ridx  (idx),
      .rbeat (ram_rbeat),
      .rdata (ram_rdata)
   );

   assign mem_rdata = (mem_resp && (op == OP_RD)) ? ram_rdata : '0;

endmodule

// File: tb/tb_pmem_burst_ctrl.sv
// Scoreboard bench for pmem_burst_ctrl: drivers push expected beats (data and
// cycle) from a line-array model, a negedge monitor pops and compares.
module tb_pmem_burst_ctrl;

   localparam int LAT   = 4;
   localparam int NB    = 4;
   localparam int NLINE = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] mem_address = '0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [63:0] mem_wdata = '0;
   logic        mem_resp;
   logic [63:0] mem_rdata;
   logic        busy;

   pmem_burst_ctrl #(
      .ADDR_W(32), .BEAT_W(64), .BEATS(NB), .LATENCY(LAT), .IDX_W(8)
   ) dut (
      .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read),
      .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] data;
      int          at;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] mdl [NLINE][NB];
   int          n_chk = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int line_of(input logic [31:0] addr);
      return int'((addr >> 5) % NLINE);
   endfunction

   // Monitor: every cycle, a strobe must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (mem_resp === 1'b1) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_resp: mem_resp high with no beat expected (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk("beat_rdata", mem_rdata, e.data);
            chk("beat_cycle", 64'(cyc), 64'(e.at));
         end
      end else begin
         chk("rdata_zero_no_resp", mem_rdata, 64'h0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_resp(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (mem_resp === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: no mem_resp within 64 cycles", name);
      end
   endtask

   task automatic finish_burst();
      chk("busy_in_done", 64'(busy), 64'h1);
      tick();
      chk("busy_after_done", 64'(busy), 64'h0);
   endtask

   // Expected beat k of a burst accepted at the edge after cycle c0 lands at c0+1+LAT+k.
   task automatic do_write(input logic [31:0] addr, input logic [NB-1:0][63:0] d);
      bit ok;
      int c0;
      int li;
      li = line_of(addr);
      mem_address = addr; mem_read = 1'b0; mem_write = 1'b1; mem_wdata = d[0];
      c0 = cyc;
      for (int k = 0; k < NB; k++) sb.push_back('{64'h0, c0 + 1 + LAT + k});
      for (int k = 0; k < NB; k++) begin
         wait_resp("write_beat", ok);
         if (!ok) begin
            sb.delete(); mem_write = 1'b0; tick(); return;
         end
         tick();
         mem_wdata = (k < NB - 1) ? d[k+1] : {$urandom, $urandom};
      end
      mem_write = 1'b0;
      for (int k = 0; k < NB; k++) mdl[li][k] = d[k];
      finish_burst();
   endtask

   task automatic do_read(input logic [31:0] addr, input bit both);
      bit ok;
      int c0;
      int li;
      li = line_of(addr);
      mem_address = addr; mem_read = 1'b1; mem_write = both; mem_wdata = {$urandom, $urandom};
      c0 = cyc;
      for (int k = 0; k < NB; k++) sb.push_back('{mdl[li][k], c0 + 1 + LAT + k});
      for (int k = 0; k < NB; k++) begin
         wait_resp("read_beat", ok);
         if (!ok) begin
            sb.delete(); mem_read = 1'b0; mem_write = 1'b0; tick(); return;
         end
         tick();
         mem_address = $urandom;
      end
      mem_read = 1'b0; mem_write = 1'b0;
      finish_burst();
   endtask

   // Read held across DONE: re-accepted in IDLE, two idle cycles after the last beat.
   task automatic do_read_b2b(input logic [31:0] addr);
      bit ok;
      int c0;
      int a2;
      int li;
      li = line_of(addr);
      mem_address = addr; mem_read = 1'b1; mem_write = 1'b0;
      c0 = cyc;
      a2 = c0 + 1 + LAT + NB + 2;
      for (int k = 0; k < NB; k++) sb.push_back('{mdl[li][k], c0 + 1 + LAT + k});
      for (int k = 0; k < NB; k++) sb.push_back('{mdl[li][k], a2 + LAT + k});
      for (int k = 0; k < 2 * NB; k++) begin
         wait_resp("b2b_beat", ok);
         if (!ok) begin
            sb.delete(); mem_read = 1'b0; tick(); return;
         end
         tick();
      end
      mem_read = 1'b0;
      finish_burst();
   endtask

   logic [NB-1:0][63:0] d;

   initial begin
      int li;
      int op;
      logic [31:0] a;

      tick();
      chk("reset_resp", 64'(mem_resp), 64'h0);
      chk("reset_busy", 64'(busy), 64'h0);
      chk("reset_rdata", mem_rdata, 64'h0);
      tick();
      rst = 1'b0;
      tick();
      chk("idle_busy", 64'(busy), 64'h0);

      // Preload lines 0..15 with random data through the write path.
      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < NB; k++) d[k] = {$urandom, $urandom};
         do_write(32'(i * 32), d);
      end

      // Line 3 pattern 0,1,2,3, then read via 0x60.
      for (int k = 0; k < NB; k++) d[k] = 64'(k);
      do_write(32'h60, d);
      do_read(32'h60, 1'b0);

      // Write 0x20 then read back; line 0 must be unchanged.
      for (int k = 0; k < NB; k++) d[k] = 64'hA0 + 64'(k);
      do_write(32'h20, d);
      do_read(32'h20, 1'b0);
      do_read(32'h00, 1'b0);

      // Read and write both high: treated as read, line 2 unchanged.
      do_read(32'h40, 1'b1);
      do_read(32'h40, 1'b0);

      // Reset during beat 1 of a write to line 5.
      li = 5;
      for (int k = 0; k < NB; k++) d[k] = 64'hC0DE_0000_0000_0000 | 64'(k);
      begin
         bit ok;
         int c0;
         mem_address = 32'hA0; mem_write = 1'b1; mem_wdata = d[0];
         c0 = cyc;
         sb.push_back('{64'h0, c0 + 1 + LAT});
         sb.push_back('{64'h0, c0 + 2 + LAT});
         wait_resp("rst_write_beat0", ok);
         tick();
         mem_wdata = d[1];
         rst = 1'b1;
         tick();
         chk("rst_mid_resp", 64'(mem_resp), 64'h0);
         chk("rst_mid_busy", 64'(busy), 64'h0);
         chk("rst_mid_rdata", mem_rdata, 64'h0);
         rst = 1'b0;
         mem_write = 1'b0;
         mdl[li][0] = d[0];
         tick();
      end
      do_read(32'hA0, 1'b0);

      // Abort in WAIT: no beats, IDLE on the following edge.
      mem_address = 32'hE0; mem_read = 1'b1;
      tick();
      tick();
      chk("abort_busy_wait", 64'(busy), 64'h1);
      mem_read = 1'b0;
      tick();
      chk("abort_busy_idle", 64'(busy), 64'h0);
      chk("abort_resp", 64'(mem_resp), 64'h0);
      for (int i = 0; i < 8; i++) tick();

      do_read_b2b(32'h60);

      // Index wrap: 0x2020 aliases line 1.
      for (int k = 0; k < NB; k++) d[k] = 64'h2020_0000_0000_0000 | 64'(k);
      do_write(32'h2020, d);
      do_read(32'h20, 1'b0);

      // Random traffic over lines 0..15 with random offset and upper bits.
      for (int n = 0; n < 40; n++) begin
         li = int'($urandom_range(0, 15));
         a = ($urandom & ~32'h0000_1FE0) | (32'(li) << 5);
         op = int'($urandom_range(0, 2));
         if (op == 1) begin
            for (int k = 0; k < NB; k++) d[k] = {$urandom, $urandom};
            do_write(a, d);
         end else begin
            do_read(a, op == 2);
         end
         for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick();
      end

      for (int i = 0; i < 4; i++) tick();
      chk("scoreboard_empty", 64'(sb.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
